// File: rtl/prim_clock_gate_ctrl_if.sv
// ============================================================================
// Module      : prim_clock_gate_ctrl_if
// Description : Control/status bundle between the idle-detect gate controller
//               and the logic that drives activity and consumes the gate enable.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface prim_clock_gate_ctrl_if;
    logic        enable_i;
    logic        busy_i;
    logic        wake_i;
    logic        en_o;
    logic        ready_o;
    logic        gated_o;
    logic [15:0] gate_events_o;

    modport master (
        output enable_i,
        output busy_i,
        output wake_i,
        input  en_o,
        input  ready_o,
        input  gated_o,
        input  gate_events_o
    );

    modport slave (
        input  enable_i,
        input  busy_i,
        input  wake_i,
        output en_o,
        output ready_o,
        output gated_o,
        output gate_events_o
    );
endinterface

`default_nettype wire

// File: rtl/prim_clock_gate_ctrl.sv
// ============================================================================
// Module      : prim_clock_gate_ctrl
// Description : Drops the clock-gate enable after IdleCycles consecutive idle
//               cycles and re-enables it on wake, holding ready low for
//               WakeCycles cycles while the gated clock settles.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module prim_clock_gate_ctrl #(
    parameter int unsigned IdleCycles = 16,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned CntW =
        $clog2(((IdleCycles > WakeCycles) ? IdleCycles : WakeCycles) + 1)
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    prim_clock_gate_ctrl_if.slave   gc
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IDLE_WAIT = 2'd1,
        ST_GATED     = 2'd2,
        ST_WAKE      = 2'd3
    } state_e;

    localparam logic [CntW-1:0] c_IDLE_LAST  = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] c_WAKE_LAST  = CntW'(WakeCycles - 1);
    localparam logic [15:0]     c_EVENTS_MAX = 16'hFFFF;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              en_q, ready_q, gated_q;
    logic [15:0]       gate_events_q;
    logic              w_idle;
    logic              w_gate_entry;

    assign w_idle = gc.enable_i & ~gc.busy_i & ~gc.wake_i;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_gate_entry = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (w_idle) begin
                    state_d = ST_IDLE_WAIT;
                    cnt_d   = CntW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_IDLE_WAIT: begin
                if (!w_idle) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == c_IDLE_LAST) begin
                    state_d      = ST_GATED;
                    cnt_d        = '0;
                    w_gate_entry = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_GATED: begin
                if (gc.wake_i | gc.busy_i | ~gc.enable_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                // Inputs are deliberately ignored: a started wake always finishes.
                if (cnt_q == c_WAKE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            en_q          <= 1'b1;
            ready_q       <= 1'b1;
            gated_q       <= 1'b0;
            gate_events_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= (state_d != ST_GATED);
            ready_q <= (state_d == ST_RUN) || (state_d == ST_IDLE_WAIT);
            gated_q <= (state_d == ST_GATED);
            if (w_gate_entry && (gate_events_q != c_EVENTS_MAX)) begin
                gate_events_q <= gate_events_q + 16'd1;
            end
        end
    end

    assign gc.en_o          = en_q;
    assign gc.ready_o       = ready_q;
    assign gc.gated_o       = gated_q;
    assign gc.gate_events_o = gate_events_q;

endmodule

`default_nettype wire

// File: tb/tb_prim_clock_gate_ctrl.sv
// ============================================================================
// Module      : tb_prim_clock_gate_ctrl
// Description : Self-checking bench for prim_clock_gate_ctrl (IdleCycles=4,
//               WakeCycles=2) against an idle-run / wake-countdown model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_prim_clock_gate_ctrl;
    localparam int c_IDLE = 4;
    localparam int c_WAKE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    // Reference model: length of the current idle run, gated flag, and
    // remaining wake cycles before the domain counts as ready again.
    int   m_idle_run  = 0;
    int   m_wake_left = 0;
    bit   m_gated     = 1'b0;
    int   m_events    = 0;

    prim_clock_gate_ctrl_if ifc ();

    prim_clock_gate_ctrl #(
        .IdleCycles (c_IDLE),
        .WakeCycles (c_WAKE)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .gc    (ifc)
    );

    always #5 clk = ~clk;

    function automatic void model_update();
        bit idle;
        idle = ifc.enable_i && !ifc.busy_i && !ifc.wake_i;
        if (rst) begin
            m_idle_run = 0; m_wake_left = 0; m_gated = 1'b0; m_events = 0;
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else if (m_gated) begin
            if (ifc.wake_i || ifc.busy_i || !ifc.enable_i) begin
                m_gated     = 1'b0;
                m_wake_left = c_WAKE;
            end
        end else if (idle) begin
            m_idle_run++;
            if (m_idle_run >= c_IDLE) begin
                m_gated    = 1'b1;
                m_idle_run = 0;
                if (m_events < 65535) m_events++;
            end
        end else begin
            m_idle_run = 0;
        end
    endfunction

    function automatic logic [18:0] model_vec();
        return {~m_gated, (~m_gated && (m_wake_left == 0)), m_gated, 16'(m_events)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {ifc.en_o, ifc.ready_o, ifc.gated_o, ifc.gate_events_o};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic e, input logic b, input logic w);
        ifc.enable_i = e;
        ifc.busy_i   = b;
        ifc.wake_i   = w;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_vec() !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), {1'b1, 1'b1, 1'b0, 16'h0000});
        end
    endtask

    task automatic test_gate_entry();
        logic exp_en;
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_en = (i < 3);
            tests++;
            if (ifc.en_o !== exp_en) begin
                fails++;
                $display("FAIL gate_entry_en edge %0d: got %b expected %b", i, ifc.en_o, exp_en);
            end
        end
        tests++;
        if ({ifc.gated_o, ifc.ready_o, ifc.gate_events_o} !== {1'b1, 1'b0, 16'd1}) begin
            fails++;
            $display("FAIL gate_entry_status: got gated=%b ready=%b events=%0d expected 1 0 1",
                     ifc.gated_o, ifc.ready_o, ifc.gate_events_o);
        end
    endtask

    task automatic test_busy_restart();
        logic exp_en;
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        set_in(1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            exp_en = (i < 3);
            tests++;
            if ({ifc.en_o, ifc.gate_events_o} !== {exp_en, 16'(exp_en ? 0 : 1)}) begin
                fails++;
                $display("FAIL busy_restart idle %0d: got en=%b events=%0d expected en=%b",
                         i, ifc.en_o, ifc.gate_events_o, exp_en);
            end
        end
    endtask

    task automatic test_wake();
        // Continues from GATED left by the previous scenario.
        set_in(1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b1, 1'b0, 1'b0);
        tests++;
        if ({ifc.en_o, ifc.gated_o, ifc.ready_o} !== 3'b100) begin
            fails++;
            $display("FAIL wake_w: got en/gated/ready=%b%b%b expected 100", ifc.en_o, ifc.gated_o, ifc.ready_o);
        end
        step();
        tests++;
        if ({ifc.en_o, ifc.ready_o} !== 2'b10) begin
            fails++;
            $display("FAIL wake_w1: got en/ready=%b%b expected 10", ifc.en_o, ifc.ready_o);
        end
        step();
        tests++;
        if ({ifc.en_o, ifc.ready_o, ifc.gated_o} !== 3'b110) begin
            fails++;
            $display("FAIL wake_w2: got en/ready/gated=%b%b%b expected 110", ifc.en_o, ifc.ready_o, ifc.gated_o);
        end
    endtask

    task automatic test_enable_off();
        int bad;
        do_reset();
        bad = 0;
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            if ({ifc.en_o, ifc.ready_o, ifc.gate_events_o} !== {2'b11, 16'h0}) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL enable_off_hold: %0d cycles wrong, expected 0", bad);
        end
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        set_in(1'b0, 1'b0, 1'b0);
        step();
        tests++;
        if ({ifc.en_o, ifc.ready_o, ifc.gated_o} !== 3'b100) begin
            fails++;
            $display("FAIL enable_drop_wake: got en/ready/gated=%b%b%b expected 100", ifc.en_o, ifc.ready_o, ifc.gated_o);
        end
        step();
        step();
        step();
        tests++;
        if (dut_vec() !== {3'b110, 16'd1}) begin
            fails++;
            $display("FAIL enable_drop_run: got %h expected %h", dut_vec(), {3'b110, 16'd1});
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        set_in(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (dut_vec() !== {3'b110, 16'h0}) begin
            fails++;
            $display("FAIL reset_in_gated: got %h expected %h", dut_vec(), {3'b110, 16'h0});
        end
        for (int i = 0; i < 4; i++) step();
        set_in(1'b1, 1'b0, 1'b1);
        step();
        set_in(1'b1, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (dut_vec() !== {3'b110, 16'h0}) begin
            fails++;
            $display("FAIL reset_in_wake: got %h expected %h", dut_vec(), {3'b110, 16'h0});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut.gate_events_q = 16'hFFFE;
        m_events = 16'hFFFE;
        #1 release dut.gate_events_q;
        set_in(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 4; i++) step();
            tests++;
            if ({ifc.gated_o, ifc.gate_events_o} !== {1'b1, 16'hFFFF}) begin
                fails++;
                $display("FAIL saturation gate %0d: got gated=%b events=%h expected 1 ffff",
                         g, ifc.gated_o, ifc.gate_events_o);
            end
            set_in(1'b1, 1'b0, 1'b1);
            step();
            set_in(1'b1, 1'b0, 1'b0);
            step();
            step();
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_in(logic'($urandom_range(0, 19) != 0),
                   logic'($urandom_range(0, 9) == 0),
                   logic'($urandom_range(0, 14) == 0));
            step();
            tests++;
            if (dut_vec() !== model_vec()) begin
                fails++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        set_in(1'b0, 1'b0, 1'b0);
        test_reset();
        test_gate_entry();
        test_busy_restart();
        test_wake();
        test_enable_off();
        test_reset_priority();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prim_clock_gate_ctrl.md
# prim_clock_gate_ctrl

Idle-detect controller that drives the enable input of the clock-gating primitive. It runs on the free-running clock and watches activity of the gated domain. After a programmable number of consecutive idle cycles it drops the gate enable. On a wake request it re-enables the clock and holds `ready_o` low until the gated clock has run a fixed number of cycles.

## Interface
- `IdleCycles`, default 16: consecutive idle cycles required before gating; legal range 2..65535.
- `WakeCycles`, default 2: cycles between `en_o` rising and `ready_o` rising; legal range 1..65535.
- `CntW`, default `$clog2(max(IdleCycles,WakeCycles)+1)`: internal counter width; derived, not overridden.

Ports:
- `clk_i` in 1: free-running (ungated) clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `enable_i` in 1: gating feature enable; 0 keeps the clock permanently on.
- `busy_i` in 1: gated domain has work in flight.
- `wake_i` in 1: external wake request (e.g. incoming transaction).
- `en_o` out 1: clock enable; connects to the gating cell `en_i`. Registered.
- `ready_o` out 1: gated domain clocked and stable; upstream may issue traffic. Registered.
- `gated_o` out 1: status, clock currently gated. Registered.
- `gate_events_o` out 16: saturating count of entries into GATED.

One clock; reset is synchronous and active-high.

## Operation
- Define `idle = enable_i & ~busy_i & ~wake_i`, sampled each `clk_i` edge.
- FSM states are RUN, IDLE_WAIT, GATED and WAKE. The counter `cnt` is CntW bits wide.

Transitions:
- RUN: if `idle`, go to IDLE_WAIT with `cnt`=1; otherwise stay with `cnt`=0.
- IDLE_WAIT:
  - if `!idle`, go to RUN with `cnt`=0;
  - else if `cnt==IdleCycles-1`, go to GATED;
  - else `cnt++`.
- GATED: if `wake_i | busy_i | ~enable_i`, go to WAKE with `cnt`=0; otherwise stay.
- WAKE: if `cnt==WakeCycles-1`, go to RUN with `cnt`=0; otherwise `cnt++`. Inputs are ignored in WAKE; a wake sequence always completes.

Outputs (all registered, decoded from next state):
- `en_o` = (state != GATED).
- `ready_o` = state ∈ {RUN, IDLE_WAIT}.
- `gated_o` = (state == GATED).

`gate_events_o` increments by 1 on every IDLE_WAIT→GATED transition and saturates at 16'hFFFF, with no wrap.

## Timing
- Reset values: state RUN, `cnt`=0, `en_o`=1, `ready_o`=1, `gated_o`=0, `gate_events_o`=0. Reset has priority in every state, including GATED and mid-WAKE. The clock comes back on in the cycle after `rst_i` is sampled high.
- Gate latency: if `idle` is sampled at edges t..t+IdleCycles-1, `en_o` is 0 after edge t+IdleCycles-1.
- A single non-idle sample anywhere in that window restarts the count from RUN.
- Wake latency:
  - wake condition sampled at edge w: `en_o` is 1 after edge w.
  - `ready_o` is 1 after edge w+WakeCycles.
- If the wake condition coincides with the final idle sample, `idle` is false, so the result is RUN, not GATED.
- `wake_i` asserted in the same cycle the FSM enters GATED is handled on the next edge. The minimum gated time is 1 cycle.
- `enable_i` falling in IDLE_WAIT returns to RUN on the next edge. Falling in GATED starts a normal WAKE.
- `busy_i` and `wake_i` are synchronous to `clk_i`; no synchronizers are inside.

## Test plan
All scenarios use IdleCycles=4, WakeCycles=2.

1. Reset, then `enable_i`=1 and `busy_i`=`wake_i`=0 from edge 0:
   - `en_o` 1 through edge 2 and 0 after edge 3;
   - `gated_o`=1 and `ready_o`=0 after edge 3;
   - `gate_events_o`=1.
2. Idle for 3 cycles, `busy_i`=1 for 1 cycle, then idle:
   - `en_o` stays 1 until 4 further consecutive idle samples;
   - `gate_events_o` unchanged until then.
3. From GATED, pulse `wake_i` at edge w:
   - `en_o`=1 after w;
   - `ready_o`=0 after w+1 and 1 after w+2;
   - `gated_o`=0 after w.
4. `enable_i`=0 with `busy_i`=0 for 100 cycles: `en_o`, `ready_o` stay 1 and `gate_events_o` stays 0. Then clear `enable_i` while GATED: WAKE completes and the FSM returns to RUN.
5. Assert `rst_i` in GATED and, separately, in WAKE with `cnt`=1: after the edge, `en_o`=1, `ready_o`=1, `gated_o`=0 and `gate_events_o`=0.
6. Force `gate_events_o` near saturation (65535 gate cycles, or preload in the bench) and perform one more gate: the count holds at 16'hFFFF.
